// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode, control-word and state types for the ALU sequencer
package alu_seq_pkg;
  localparam int C = 2;
  localparam int N = 1;
  localparam int Z = 0;
  typedef enum logic [3:0] {
    OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDC, OP_SUB, OP_CMP,
    OP_INC, OP_DEC, OP_NEG, OP_NOT, OP_SHL1, OP_SHR1, OP_ADD16, OP_SUB16
  } op_e;
  typedef enum logic [2:0] {
    OUT_ZERO, OUT_AND, OUT_OR, OUT_XOR, OUT_ADD, OUT_SHIFT, OUT_NOT_A, OUT_ONE
  } out_sel_e;
  typedef struct packed {
    logic sel_a_mux;
    logic sel_b_mux;
    logic sel_gd_b_mux;
    logic sel_bit_mux;
    logic sel_shift_mux;
    logic shift_dir;
    logic shift_mode;
    out_sel_e sel_out_mux;
    logic byte_sel;
    logic res_we;
  } ctrl_word_t;
  typedef enum logic [1:0] {IDLE, EXEC, EXEC_HI} state_e;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: opcode handshake, ALU control word and flag signals
interface alu_sequencer_if #(parameter int OP_W = 4);
  logic op_valid;
  logic [OP_W-1:0] op_code;
  logic op_ready;
  logic sel_a_mux;
  logic sel_b_mux;
  logic sel_gd_b_mux;
  logic sel_bit_mux;
  logic sel_shift_mux;
  logic shift_dir;
  logic shift_mode;
  logic [2:0] sel_out_mux;
  logic byte_sel;
  logic res_we;
  logic [2:0] alu_flags;
  logic [2:0] flags_q;
  logic busy;
  modport master (
    output op_valid, op_code, alu_flags,
    input op_ready, sel_a_mux, sel_b_mux, sel_gd_b_mux, sel_bit_mux, sel_shift_mux,
    shift_dir, shift_mode, sel_out_mux, byte_sel, res_we, flags_q, busy
  );
  modport slave (
    input op_valid, op_code, alu_flags,
    output op_ready, sel_a_mux, sel_b_mux, sel_gd_b_mux, sel_bit_mux, sel_shift_mux,
    shift_dir, shift_mode, sel_out_mux, byte_sel, res_we, flags_q, busy
  );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps an opcode, byte phase and carry to the ALU control word
module alu_op_decode
  import alu_seq_pkg::*;
(
  input op_e op,
  input logic hi_phase,
  input logic carry_in,
  output ctrl_word_t ctrl
);
  always_comb begin
    ctrl = ctrl_word_t'(0);
    ctrl.res_we = !(op inside {OP_NOP, OP_CMP});
    case (op)
      OP_AND: ctrl.sel_out_mux = OUT_AND;
      OP_OR: ctrl.sel_out_mux = OUT_OR;
      OP_XOR: ctrl.sel_out_mux = OUT_XOR;
      OP_ADD: ctrl.sel_out_mux = OUT_ADD;
      OP_ADDC: begin
        ctrl.sel_out_mux = OUT_ADD;
        ctrl.sel_bit_mux = carry_in;
      end
      OP_SUB, OP_CMP: begin
        ctrl.sel_out_mux = OUT_ADD;
        ctrl.sel_b_mux = 1'b1;
        ctrl.sel_bit_mux = 1'b1;
      end
      OP_INC: begin
        ctrl.sel_out_mux = OUT_ADD;
        ctrl.sel_gd_b_mux = 1'b1;
        ctrl.sel_bit_mux = 1'b1;
      end
      OP_DEC: begin
        ctrl.sel_out_mux = OUT_ADD;
        ctrl.sel_gd_b_mux = 1'b1;
        ctrl.sel_b_mux = 1'b1;
      end
      OP_NEG: begin
        ctrl.sel_out_mux = OUT_ADD;
        ctrl.sel_a_mux = 1'b1;
        ctrl.sel_gd_b_mux = 1'b1;
        ctrl.sel_bit_mux = 1'b1;
      end
      OP_NOT: ctrl.sel_out_mux = OUT_NOT_A;
      OP_SHL1, OP_SHR1: begin
        ctrl.sel_out_mux = OUT_SHIFT;
        ctrl.sel_bit_mux = 1'b1;
        ctrl.shift_dir = op == OP_SHR1;
      end
      OP_ADD16, OP_SUB16: begin
        ctrl.sel_out_mux = OUT_ADD;
        ctrl.byte_sel = hi_phase;
        ctrl.sel_b_mux = op == OP_SUB16;
        ctrl.sel_bit_mux = hi_phase ? carry_in : op == OP_SUB16;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts opcodes, sequences the registered ALU control word and keeps the flag register
module alu_sequencer
  import alu_seq_pkg::*;
#(parameter int OP_W = 4)
(
  input logic clk,
  input logic reset,
  alu_sequencer_if.slave bus
);
  state_e state, state_n;
  op_e op_q, op_n;
  ctrl_word_t ctrl_q, ctrl_d, dec;
  logic [2:0] flags, flags_n;
  logic z_lo;
  logic wide;
  logic flag_ld;
  assign wide = op_q inside {OP_ADD16, OP_SUB16};
  alu_op_decode u_dec (
    .op(op_n),
    .hi_phase(state_n == EXEC_HI),
    .carry_in(flags_n[C]),
    .ctrl(dec)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q <= OP_NOP;
      ctrl_q <= ctrl_word_t'(0);
      flags <= 3'b000;
      z_lo <= 1'b0;
    end else begin
      state <= state_n;
      op_q <= op_n;
      ctrl_q <= ctrl_d;
      flags <= flags_n;
      z_lo <= (state == EXEC && wide) ? bus.alu_flags[Z] : z_lo;
    end
  end
  always_comb begin
    op_n = (state == IDLE && bus.op_valid) ? op_e'(bus.op_code[OP_W-1:0]) : op_q;
    state_n = state == IDLE ? (bus.op_valid ? EXEC : IDLE) : ((state == EXEC && wide) ? EXEC_HI : IDLE);
  end
  always_comb begin
    flag_ld = state != IDLE && ctrl_q.sel_out_mux == OUT_ADD;
    flags_n = !flag_ld ? flags :
              state == EXEC_HI ? {bus.alu_flags[C], bus.alu_flags[N], bus.alu_flags[Z] & z_lo} :
              bus.alu_flags;
    ctrl_d = state_n == IDLE ? ctrl_word_t'(0) : dec;
  end
  assign bus.op_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.sel_a_mux = ctrl_q.sel_a_mux;
  assign bus.sel_b_mux = ctrl_q.sel_b_mux;
  assign bus.sel_gd_b_mux = ctrl_q.sel_gd_b_mux;
  assign bus.sel_bit_mux = ctrl_q.sel_bit_mux;
  assign bus.sel_shift_mux = ctrl_q.sel_shift_mux;
  assign bus.shift_dir = ctrl_q.shift_dir;
  assign bus.shift_mode = ctrl_q.shift_mode;
  assign bus.sel_out_mux = ctrl_q.sel_out_mux;
  assign bus.byte_sel = ctrl_q.byte_sel;
  assign bus.res_we = ctrl_q.res_we;
  assign bus.flags_q = flags;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench driving an 8-bit ALU stand-in from the control word
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  int passed = 0;
  int total = 0;
  logic [15:0] opa = 16'h0, opb = 16'h0;
  logic [7:0] xa, xb, bb, sx, result;
  logic [8:0] sum;
  always_comb begin
    xa = bus.byte_sel ? opa[15:8] : opa[7:0];
    xb = bus.byte_sel ? opb[15:8] : opb[7:0];
    bb = bus.sel_gd_b_mux ? 8'h00 : xb;
    sum = {1'b0, (bus.sel_a_mux ? ~xa : xa)} + {1'b0, (bus.sel_b_mux ? ~bb : bb)} + {8'h00, bus.sel_bit_mux};
    sx = bus.sel_shift_mux ? xb : xa;
    case (bus.sel_out_mux)
      3'd1: result = xa & xb;
      3'd2: result = xa | xb;
      3'd3: result = xa ^ xb;
      3'd4: result = sum[7:0];
      3'd5: result = bus.shift_dir ? {bus.sel_bit_mux, sx[7:1]} : {sx[6:0], bus.sel_bit_mux};
      3'd6: result = ~xa;
      3'd7: result = 8'hFF;
      default: result = 8'h00;
    endcase
    bus.alu_flags = {sum[8], sum[7], sum[7:0] == 8'h00};
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] f, output logic w, output logic [15:0] r, output logic [2:0] nf);
    int x, y, s;
    x = int'(a[7:0]);
    y = int'(b[7:0]);
    s = 0;
    r = 16'h0;
    nf = f;
    w = !(op == 4'd0 || op == 4'd7);
    case (op)
      4'd1: r = {8'h00, a[7:0] & b[7:0]};
      4'd2: r = {8'h00, a[7:0] | b[7:0]};
      4'd3: r = {8'h00, a[7:0] ^ b[7:0]};
      4'd4: s = x + y;
      4'd5: s = x + y + int'(f[2]);
      4'd6, 4'd7: s = x - y + 256;
      4'd8: s = x + 1;
      4'd9: s = x - 1 + 256;
      4'd10: s = 256 - x;
      4'd11: r = {8'h00, ~a[7:0]};
      4'd12: r = {8'h00, a[6:0], 1'b1};
      4'd13: r = {8'h00, 1'b1, a[7:1]};
      4'd14: s = int'(a) + int'(b);
      4'd15: s = int'(a) - int'(b) + 65536;
      default: ;
    endcase
    if (op >= 4'd4 && op <= 4'd10) begin
      r = {8'h00, s[7:0]};
      nf = {s[8], s[7], s[7:0] == 8'h00};
    end
    if (op >= 4'd14) begin
      r = s[15:0];
      nf = {s[16], s[15], s[15:0] == 16'h0};
    end
  endfunction
  task automatic exec_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [2:0] w, output logic [15:0] r, output logic [1:0] bs,
                         output logic [1:0] bm, output logic [2:0] fl);
    int n = 0;
    opa = a;
    opb = b;
    while (!bus.op_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready) begin
      $display("FAIL ready_timeout: op_ready=%b required 1", bus.op_ready);
      $fatal(1);
    end
    bus.op_valid = 1'b1;
    bus.op_code = op;
    @(negedge clk);
    bus.op_valid = 1'b0;
    w[0] = bus.res_we;
    r[7:0] = result;
    bs[0] = bus.byte_sel;
    bm[0] = bus.sel_bit_mux;
    @(negedge clk);
    w[1] = bus.res_we;
    r[15:8] = result;
    bs[1] = bus.byte_sel;
    bm[1] = bus.sel_bit_mux;
    fl = bus.flags_q;
    @(negedge clk);
    w[2] = bus.res_we;
    if (op >= 4'd14) fl = bus.flags_q;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++;
    if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL reset_handshake: ready/busy=%b%b required 10", bus.op_ready, bus.busy);
    else passed++;
    total++;
    if (bus.res_we !== 1'b0 || bus.byte_sel !== 1'b0 || bus.sel_out_mux !== 3'd0 || bus.sel_bit_mux !== 1'b0)
      $display("FAIL reset_ctrl: we/bsel/out/bit=%b/%b/%0d/%b required 0/0/0/0", bus.res_we, bus.byte_sel, bus.sel_out_mux, bus.sel_bit_mux);
    else passed++;
    total++;
    if (bus.flags_q !== 3'b000) $display("FAIL reset_flags: got %b required 000", bus.flags_q);
    else passed++;
  endtask
  task automatic test_sub();
    logic [2:0] w, fl;
    logic [15:0] r;
    logic [1:0] bs, bm;
    exec_op(4'd6, 16'h0005, 16'h0003, w, r, bs, bm, fl);
    total++;
    if (w !== 3'b001) $display("FAIL sub_we: got %b required 001", w);
    else passed++;
    total++;
    if (r[7:0] !== 8'h02) $display("FAIL sub_result: got %h required 02", r[7:0]);
    else passed++;
    total++;
    if (fl !== 3'b100) $display("FAIL sub_flags: got %b required 100", fl);
    else passed++;
  endtask
  task automatic test_cmp();
    logic [2:0] w, fl;
    logic [15:0] r;
    logic [1:0] bs, bm;
    exec_op(4'd7, 16'h0003, 16'h0003, w, r, bs, bm, fl);
    total++;
    if (w !== 3'b000) $display("FAIL cmp_we: got %b required 000", w);
    else passed++;
    total++;
    if (fl !== 3'b101) $display("FAIL cmp_flags: got %b required 101", fl);
    else passed++;
  endtask
  task automatic test_add16();
    logic [2:0] w, fl;
    logic [15:0] r;
    logic [1:0] bs, bm;
    exec_op(4'd14, 16'h00FF, 16'h0001, w, r, bs, bm, fl);
    total++;
    if (w !== 3'b011 || bs !== 2'b10) $display("FAIL add16_phases: we=%b bsel=%b required 011/10", w, bs);
    else passed++;
    total++;
    if (bm[1] !== 1'b1) $display("FAIL add16_carry_chain: hi bit mux=%b required 1", bm[1]);
    else passed++;
    total++;
    if (r !== 16'h0100) $display("FAIL add16_result: got %h required 0100", r);
    else passed++;
    total++;
    if (fl !== 3'b000) $display("FAIL add16_flags: got %b required 000", fl);
    else passed++;
  endtask
  task automatic test_addc();
    logic [2:0] w, fl;
    logic [15:0] r;
    logic [1:0] bs, bm;
    exec_op(4'd4, 16'h00FF, 16'h0001, w, r, bs, bm, fl);
    total++;
    if (fl !== 3'b101 || r[7:0] !== 8'h00) $display("FAIL add_wrap: flags=%b result=%h required 101/00", fl, r[7:0]);
    else passed++;
    exec_op(4'd5, 16'h0000, 16'h0000, w, r, bs, bm, fl);
    total++;
    if (bm[0] !== 1'b1) $display("FAIL addc_bit: got %b required 1", bm[0]);
    else passed++;
    total++;
    if (r[7:0] !== 8'h01 || fl !== 3'b000) $display("FAIL addc_result: result=%h flags=%b required 01/000", r[7:0], fl);
    else passed++;
  endtask
  task automatic test_xor_stream();
    logic [2:0] w, fl;
    logic [15:0] r;
    logic [1:0] bs, bm;
    int acc = 0;
    int wr = 0;
    exec_op(4'd7, 16'h0003, 16'h0003, w, r, bs, bm, fl);
    opa = 16'h00A5;
    opb = 16'h003C;
    bus.op_valid = 1'b1;
    bus.op_code = 4'd3;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.op_ready !== ((i % 2) == 0)) $display("FAIL xor_ready_%0d: got %b required %b", i, bus.op_ready, (i % 2) == 0);
      else passed++;
      acc += int'(bus.op_ready);
      @(negedge clk);
      wr += int'(bus.res_we);
      if (bus.res_we) begin
        total++;
        if (result !== 8'h99) $display("FAIL xor_result: got %h required 99", result);
        else passed++;
      end
    end
    bus.op_valid = 1'b0;
    total++;
    if (wr !== acc || wr !== 4) $display("FAIL xor_writes: writes=%0d accepts=%0d required 4/4", wr, acc);
    else passed++;
    total++;
    if (bus.flags_q !== 3'b101) $display("FAIL xor_flags: got %b required 101", bus.flags_q);
    else passed++;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    logic [2:0] w, fl;
    logic [15:0] r;
    logic [1:0] bs, bm;
    exec_op(4'd6, 16'h0005, 16'h0003, w, r, bs, bm, fl);
    opa = 16'h1234;
    opb = 16'h0101;
    bus.op_valid = 1'b1;
    bus.op_code = 4'd15;
    @(negedge clk);
    bus.op_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (bus.res_we !== 1'b0 || bus.byte_sel !== 1'b0 || bus.busy !== 1'b0 || bus.op_ready !== 1'b1)
      $display("FAIL reset_exec: we/bsel/busy/ready=%b%b%b%b required 0001", bus.res_we, bus.byte_sel, bus.busy, bus.op_ready);
    else passed++;
    total++;
    if (bus.flags_q !== 3'b000) $display("FAIL reset_exec_flags: got %b required 000", bus.flags_q);
    else passed++;
    exec_op(4'd6, 16'h0005, 16'h0003, w, r, bs, bm, fl);
    bus.op_valid = 1'b1;
    bus.op_code = 4'd15;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.byte_sel !== 1'b1 || bus.res_we !== 1'b1) $display("FAIL sub16_hi_phase: bsel/we=%b%b required 11", bus.byte_sel, bus.res_we);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (bus.res_we !== 1'b0 || bus.busy !== 1'b0 || bus.op_ready !== 1'b1 || bus.flags_q !== 3'b000)
      $display("FAIL reset_exec_hi: we/busy/ready/flags=%b%b%b/%b required 001/000", bus.res_we, bus.busy, bus.op_ready, bus.flags_q);
    else passed++;
  endtask
  task automatic test_random();
    logic [2:0] w, fl, mf, ef;
    logic [15:0] r, er, a, b;
    logic [1:0] bs, bm;
    logic [3:0] op;
    logic ew, wide;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mf = 3'b000;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
      model(op, a, b, mf, ew, er, ef);
      wide = op >= 4'd14;
      exec_op(op, a, b, w, r, bs, bm, fl);
      total++;
      if (w !== (wide ? {1'b0, ew, ew} : {2'b00, ew})) $display("FAIL rand_we op=%0d: got %b", op, w);
      else passed++;
      if (ew) begin
        total++;
        if ((wide ? r : {8'h00, r[7:0]}) !== er) $display("FAIL rand_result op=%0d a=%h b=%h: got %h required %h", op, a, b, wide ? r : {8'h00, r[7:0]}, er);
        else passed++;
      end
      if (wide) begin
        total++;
        if (bs !== 2'b10) $display("FAIL rand_bsel op=%0d: got %b required 10", op, bs);
        else passed++;
      end
      total++;
      if (fl !== ef) $display("FAIL rand_flags op=%0d a=%h b=%h: got %b required %b", op, a, b, fl, ef);
      else passed++;
      mf = ef;
    end
  endtask
  initial begin
    bus.op_valid = 1'b0;
    bus.op_code = 4'd0;
    test_reset();
    test_sub();
    test_cmp();
    test_add16();
    test_addc();
    test_xor_stream();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
